toplevel_engine: RTL and testbench

TOPLEVEL_ENGINE -- requirements
Module: toplevel

---
 rtl/toplevel_engine.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_toplevel_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toplevel_engine.sv
// toplevel_engine: three-program engine over a 256 x 8 data memory.
//   Program 1 Hamming-encodes 15 messages, program 2 SECDED-decodes 15 words,
//   program 3 counts 5-bit pattern hits in a 32-byte string.
// Modules in this file:
//   engine_mem      - 256 x 8 memory, two async read ports, two sync write
//                     ports (port a writes a byte pair addr/addr+1, port b a byte)
//   engine_dp       - per-program address generation, compute and counters
//   toplevel_engine - sequencing FSM, program selector, item index
// Top ports:
//   CLK   in  system clock
//   RESET in  synchronous active-high reset
//   START in  request to run the next program
//   DONE  out high in FIN until START is next sampled high

module engine_mem (
    input  logic        clk,
    input  logic [7:0]  rd_addr_a,
    output logic [7:0]  rd_data_a,
    input  logic [7:0]  rd_addr_b,
    output logic [7:0]  rd_data_b,
    input  logic        wr_en_a,
    input  logic [7:0]  wr_addr_a,
    input  logic [15:0] wr_data_a,
    input  logic        wr_en_b,
    input  logic [7:0]  wr_addr_b,
    input  logic [7:0]  wr_data_b
);
    logic [7:0] core [0:255];

    assign rd_data_a = core[rd_addr_a];
    assign rd_data_b = core[rd_addr_b];

    // Port a stores a little-endian byte pair; every result the programs
    // emit in pairs starts on an even address.
    always_ff @(posedge clk) begin
        if (wr_en_a) begin
            core[wr_addr_a]         <= wr_data_a[7:0];
            core[wr_addr_a + 8'd1]  <= wr_data_a[15:8];
        end
        if (wr_en_b) begin
            core[wr_addr_b] <= wr_data_b;
        end
    end
endmodule

module engine_dp (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] psel,
    input  logic [4:0] idx
);
    logic [7:0]  rd_addr_a, rd_addr_b, rd_data_a, rd_data_b;
    logic        wr_en_a, wr_en_b;
    logic [7:0]  wr_addr_a, wr_addr_b, wr_data_b;
    logic [15:0] wr_data_a;
    logic [7:0]  two_i;
    logic [7:0]  ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d, prev_q, prev_d;
    logic [2:0]  n_in, n_cross;
    logic        last;

    engine_mem dm (
        .clk       (clk),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en_a   (wr_en_a),
        .wr_addr_a (wr_addr_a),
        .wr_data_a (wr_data_a),
        .wr_en_b   (wr_en_b),
        .wr_addr_b (wr_addr_b),
        .wr_data_b (wr_data_b)
    );

    function automatic logic [15:0] hamming_enc(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    function automatic logic [15:0] secded_dec(input logic [15:0] w_in);
        logic [15:0] w;
        logic [3:0]  s;
        logic        p;
        logic [4:0]  status;
        w = w_in;
        s = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ k[3:0];
        end
        p = ^w;
        if (p) begin
            status = 5'b01000;
            // S == 0 with odd parity means only the overall parity bit flipped.
            if (s != 4'd0) w[s] = ~w[s];
        end else if (s == 4'd0) begin
            status = 5'b00000;
        end else begin
            status = 5'b10000;
        end
        return {status, w[15:9], w[7:5], w[3]};
    endfunction

    function automatic logic [2:0] count_inbyte(input logic [7:0] b, input logic [4:0] pat);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (b[k +: 5] == pat) n = n + 3'd1;
        end
        return n;
    endfunction

    // Windows starting at bits 4..7 of {prev, cur} straddle the byte boundary.
    function automatic logic [2:0] count_cross(input logic [15:0] pair, input logic [4:0] pat);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 4; k < 8; k++) begin
            if (pair[k +: 5] == pat) n = n + 3'd1;
        end
        return n;
    endfunction

    assign two_i = {2'b00, idx, 1'b0};
    assign last  = (idx == 5'd31);

    // Program 3 reads the current byte on port a and the pattern on port b;
    // the previous byte is carried in prev_q for the crossing windows.
    always_comb begin
        rd_addr_a = two_i;
        rd_addr_b = two_i + 8'd1;
        case (psel)
            2'd2: begin
                rd_addr_a = 8'd64 + two_i;
                rd_addr_b = 8'd65 + two_i;
            end
            2'd3: begin
                rd_addr_a = 8'd128 + {3'b000, idx};
                rd_addr_b = 8'd160;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_en_a   = 1'b0;
        wr_addr_a = 8'd0;
        wr_data_a = 16'd0;
        wr_en_b   = 1'b0;
        wr_addr_b = 8'd0;
        wr_data_b = 8'd0;
        n_in      = 3'd0;
        n_cross   = 3'd0;
        ctb_d     = 8'd0;
        cto_d     = 8'd0;
        cts_d     = 8'd0;
        prev_d    = prev_q;
        case (psel)
            2'd1: begin
                wr_en_a   = run;
                wr_addr_a = 8'd30 + two_i;
                wr_data_a = hamming_enc({rd_data_b[2:0], rd_data_a});
            end
            2'd2: begin
                wr_en_a   = run;
                wr_addr_a = 8'd94 + two_i;
                wr_data_a = secded_dec({rd_data_b, rd_data_a});
            end
            2'd3: begin
                n_in    = count_inbyte(rd_data_a, rd_data_b[4:0]);
                n_cross = (idx != 5'd0) ? count_cross({prev_q, rd_data_a}, rd_data_b[4:0]) : 3'd0;
                if (run) begin
                    ctb_d  = ctb_q + {5'd0, n_in};
                    cto_d  = cto_q + {7'd0, (n_in != 3'd0)};
                    cts_d  = cts_q + {5'd0, n_in} + {5'd0, n_cross};
                    prev_d = rd_data_a;
                end
                wr_en_a   = run && last;
                wr_addr_a = 8'd192;
                wr_data_a = {cto_d, ctb_d};
                wr_en_b   = run && last;
                wr_addr_b = 8'd194;
                wr_data_b = cts_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctb_q  <= 8'd0;
            cto_q  <= 8'd0;
            cts_q  <= 8'd0;
            prev_q <= 8'd0;
        end else begin
            ctb_q  <= ctb_d;
            cto_q  <= cto_d;
            cts_q  <= cts_d;
            prev_q <= prev_d;
        end
    end
endmodule

// state | meaning
// IDLE  | after reset, waiting for START
// ARMED | START seen, waiting for it to drop
// RUN   | processing one item per cycle
// FIN   | run complete, DONE high until START
module toplevel_engine (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    output logic DONE
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, FIN} state_t;

    state_t     state_q, state_d;
    logic [1:0] psel_q, psel_d;
    logic [4:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [4:0] last_idx;
    logic       run;

    // Writes are blocked on a reset edge so a mid-run reset leaves only the
    // items already completed.
    assign run      = (state_q == RUN) && !RESET;
    assign last_idx = (psel_q == 2'd3) ? 5'd31 : 5'd14;
    assign DONE     = done_q;

    always_comb begin
        state_d = state_q;
        psel_d  = psel_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:  if (START) state_d = ARMED;
            ARMED: begin
                if (!START) begin
                    state_d = RUN;
                    idx_d   = 5'd0;
                end
            end
            RUN: begin
                if (idx_q == last_idx) begin
                    state_d = FIN;
                    idx_d   = 5'd0;
                    psel_d  = (psel_q == 2'd3) ? 2'd1 : psel_q + 2'd1;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            FIN:   if (START) state_d = ARMED;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            psel_q  <= 2'd1;
            idx_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psel_q  <= psel_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    engine_dp dp (
        .clk  (CLK),
        .rst  (RESET),
        .run  (run),
        .psel (psel_q),
        .idx  (idx_q)
    );
endmodule

// File: tb/tb_toplevel_engine.sv
// tb_toplevel_engine: self-checking bench for toplevel_engine.
//   Keeps a shadow copy of the data memory, preloads the DUT through the
//   memory backdoor, and after every run compares the whole DUT memory with
//   the shadow updated by a positional reference model of each program.
//   Known vectors live in a table; the rest of each program's inputs are random.

module tb_toplevel_engine;
    logic clk = 1'b0;
    logic rst, start, done;

    always #5 clk = ~clk;

    toplevel_engine dut (
        .CLK   (clk),
        .RESET (rst),
        .START (start),
        .DONE  (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] shadow [256];

    typedef struct {
        int          prog;
        int          slot;
        logic [15:0] in_val;
        logic [15:0] exp_val;
    } vec_t;
    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp_v);
        end
    endtask

    task automatic put(input int a, input logic [7:0] v);
        shadow[a] = v;
        dut.dp.dm.core[a] = v;
    endtask

    // Hamming(15,11)+overall parity built by position: data goes to the
    // non-power-of-two positions, parity bit 2^b covers positions with bit b set.
    function automatic logic [15:0] ham_ref(input logic [10:0] d);
        logic [15:0] w;
        logic [3:0]  syn;
        int n;
        w = '0;
        n = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[n];
                n++;
            end
        end
        syn = '0;
        for (int pos = 1; pos < 16; pos++) if (w[pos]) syn ^= pos[3:0];
        w[1] = syn[0];
        w[2] = syn[1];
        w[4] = syn[2];
        w[8] = syn[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [15:0] dec_ref(input logic [15:0] w_in);
        logic [15:0] w;
        logic [3:0]  syn;
        logic [10:0] d;
        logic [4:0]  status;
        int n;
        w = w_in;
        syn = '0;
        for (int pos = 1; pos < 16; pos++) if (w[pos]) syn ^= pos[3:0];
        if (^w) begin
            status = 5'b01000;
            if (syn != 0) w[syn] = ~w[syn];
        end else if (syn == 0) begin
            status = 5'b00000;
        end else begin
            status = 5'b10000;
        end
        d = '0;
        n = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[n] = w[pos];
                n++;
            end
        end
        return {status, d};
    endfunction

    task automatic model_p1();
        logic [15:0] w;
        for (int i = 0; i < 15; i++) begin
            w = ham_ref({shadow[2*i+1][2:0], shadow[2*i]});
            shadow[30+2*i] = w[7:0];
            shadow[31+2*i] = w[15:8];
        end
    endtask

    task automatic model_p2(input int n_items);
        logic [15:0] r;
        for (int i = 0; i < n_items; i++) begin
            r = dec_ref({shadow[65+2*i], shadow[64+2*i]});
            shadow[94+2*i] = r[7:0];
            shadow[95+2*i] = r[15:8];
        end
    endtask

    // 256-bit string, bit m counted from the MSB of byte 0; a window starting
    // at m lies inside one byte when m % 8 <= 3.
    task automatic model_p3();
        logic [255:0] s;
        logic [4:0]   pat, win;
        bit           hit [32];
        int ctb, cto, cts;
        for (int j = 0; j < 32; j++) begin
            s[255-8*j -: 8] = shadow[128+j];
            hit[j] = 1'b0;
        end
        pat = shadow[160][4:0];
        ctb = 0; cto = 0; cts = 0;
        for (int m = 0; m < 252; m++) begin
            for (int t = 0; t < 5; t++) win[4-t] = s[255-m-t];
            if (win == pat) begin
                cts++;
                if ((m % 8) <= 3) begin
                    ctb++;
                    hit[m/8] = 1'b1;
                end
            end
        end
        for (int j = 0; j < 32; j++) if (hit[j]) cto++;
        shadow[192] = 8'(ctb);
        shadow[193] = 8'(cto);
        shadow[194] = 8'(cts);
    endtask

    task automatic check_image(input string name);
        int bad = 0;
        int ba  = 0;
        for (int a = 0; a < 256; a++) begin
            if (dut.dp.dm.core[a] !== shadow[a]) begin
                if (bad == 0) ba = a;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_image: %0d bytes differ, first at %0d got 0x%0h expected 0x%0h",
                     name, bad, ba, dut.dp.dm.core[ba], shadow[ba]);
        end
    endtask

    task automatic run_prog(input int run_len, input string name, input bit poke);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_armed_done"}, 32'(done), 0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (poke && n == 2) start = 1'b1;
            if (poke && n == 4) start = 1'b0;
        end
        check({name, "_latency"}, n, run_len + 1);
        repeat (3) tick();
        check({name, "_done_hold"}, 32'(done), 1);
    endtask

    task automatic check_table(input int prog, input string name);
        int lo;
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].prog == prog) begin
                lo = (prog == 1) ? 30 + 2*vecs[v].slot : 94 + 2*vecs[v].slot;
                check($sformatf("%s_vec%0d", name, v),
                      {16'd0, dut.dp.dm.core[lo+1], dut.dp.dm.core[lo]}, {16'd0, vecs[v].exp_val});
            end
        end
    endtask

    task automatic rand_p1(input int first);
        for (int i = first; i < 15; i++) begin
            put(2*i,   8'($urandom));
            put(2*i+1, 8'($urandom));
        end
    endtask

    task automatic rand_p2(input int first);
        logic [15:0] w;
        int b1, b2;
        for (int i = first; i < 15; i++) begin
            w  = ham_ref(11'($urandom));
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 3))
                0: ;
                1: w[b1] = ~w[b1];
                2: begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
                default: w = 16'($urandom);
            endcase
            put(64+2*i, w[7:0]);
            put(65+2*i, w[15:8]);
        end
    endtask

    task automatic rand_p3();
        logic [7:0] pat_b;
        pat_b = 8'($urandom);
        put(160, pat_b);
        for (int j = 0; j < 32; j++) begin
            // Mix pattern-rich bytes with noise so matches are frequent.
            if ($urandom_range(0, 1) == 0) put(128+j, {pat_b[4:0], pat_b[4:2]});
            else put(128+j, 8'($urandom));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        vecs = '{
            '{1, 0, 16'h07FF, 16'hFFFF},
            '{1, 1, 16'h0001, 16'h000F},
            '{1, 2, 16'h0002, 16'h0033},
            '{1, 3, 16'h0400, 16'h8117},
            '{2, 0, 16'hFFFF, 16'h07FF},
            '{2, 1, 16'hFFDF, 16'h47FF},
            '{2, 2, 16'hFDDF, 16'h87ED},
            '{2, 3, 16'h0000, 16'h0000},
            '{2, 4, 16'h0001, 16'h4000},
            '{2, 5, 16'h8117, 16'h0400}
        };

        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 256; a++) put(a, 8'($urandom));
        tick();
        tick();
        check("reset_done", 32'(done), 0);
        check("reset_psel", 32'(dut.psel_q), 1);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_done", 32'(done), 0);

        // Program 1 with table vectors in the first slots.
        rand_p1(4);
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].prog == 1) begin
                r = 8'($urandom);
                put(2*vecs[v].slot, vecs[v].in_val[7:0]);
                put(2*vecs[v].slot + 1, {(vecs[v].slot >= 2) ? r[7:3] : 5'd0, vecs[v].in_val[10:8]});
            end
        end
        run_prog(15, "p1_table", 1'b0);
        model_p1();
        check_table(1, "p1");
        check_image("p1_table");

        // Program 2 with table vectors; START pulsed during RUN must be ignored.
        rand_p2(6);
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].prog == 2) begin
                put(64 + 2*vecs[v].slot, vecs[v].in_val[7:0]);
                put(65 + 2*vecs[v].slot, vecs[v].in_val[15:8]);
            end
        end
        run_prog(15, "p2_table", 1'b1);
        model_p2(15);
        check_table(2, "p2");
        check_image("p2_table");

        // Program 3 all-ones corner.
        put(160, 8'h1F);
        for (int j = 0; j < 32; j++) put(128+j, 8'hFF);
        run_prog(32, "p3_ones", 1'b0);
        model_p3();
        check("p3_ones_ctb", 32'(dut.dp.dm.core[192]), 128);
        check("p3_ones_cto", 32'(dut.dp.dm.core[193]), 32);
        check("p3_ones_cts", 32'(dut.dp.dm.core[194]), 252);
        check_image("p3_ones");

        rand_p1(0);
        run_prog(15, "p1_rand0", 1'b0);
        model_p1();
        check_image("p1_rand0");

        rand_p2(0);
        run_prog(15, "p2_rand0", 1'b0);
        model_p2(15);
        check_image("p2_rand0");

        // Program 3 alternating-bit corner.
        put(160, 8'h15);
        for (int j = 0; j < 32; j++) put(128+j, 8'h55);
        run_prog(32, "p3_alt", 1'b0);
        model_p3();
        check("p3_alt_ctb", 32'(dut.dp.dm.core[192]), 64);
        check("p3_alt_cto", 32'(dut.dp.dm.core[193]), 32);
        check("p3_alt_cts", 32'(dut.dp.dm.core[194]), 126);
        check_image("p3_alt");

        for (int rnd = 0; rnd < 2; rnd++) begin
            rand_p1(0);
            run_prog(15, $sformatf("p1_r%0d", rnd), 1'b0);
            model_p1();
            check_image($sformatf("p1_r%0d", rnd));
            rand_p2(0);
            run_prog(15, $sformatf("p2_r%0d", rnd), 1'b0);
            model_p2(15);
            check_image($sformatf("p2_r%0d", rnd));
            rand_p3();
            run_prog(32, $sformatf("p3_r%0d", rnd), 1'b0);
            model_p3();
            check_image($sformatf("p3_r%0d", rnd));
        end

        // Reset in the middle of program 2: three items written, then reset.
        rand_p1(0);
        run_prog(15, "p1_pre", 1'b0);
        model_p1();
        check_image("p1_pre");
        rand_p2(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_done", 32'(done), 0);
        check("midreset_psel", 32'(dut.psel_q), 1);
        model_p2(3);
        check_image("midreset");
        repeat (2) tick();
        check("midreset_idle_done", 32'(done), 0);

        rand_p1(0);
        run_prog(15, "p1_after_reset", 1'b0);
        model_p1();
        check_image("p1_after_reset");
        check("psel_after_p1", 32'(dut.psel_q), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
